// File: rtl/sdp_nrdma_operand_join_if.sv
// sdp_nrdma_operand_join_if: ALU/MUL operand input streams and joined output stream
interface sdp_nrdma_operand_join_if #(parameter int DW = 256);
  logic          alu_in_valid;
  logic          alu_in_ready;
  logic [DW:0]   alu_in_pd;
  logic          mul_in_valid;
  logic          mul_in_ready;
  logic [DW:0]   mul_in_pd;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_alu_data;
  logic [DW-1:0] out_mul_data;
  logic          out_last;
  modport master (
    output alu_in_valid, alu_in_pd, mul_in_valid, mul_in_pd, out_ready,
    input  alu_in_ready, mul_in_ready, out_valid, out_alu_data, out_mul_data, out_last
  );
  modport slave (
    input  alu_in_valid, alu_in_pd, mul_in_valid, mul_in_pd, out_ready,
    output alu_in_ready, mul_in_ready, out_valid, out_alu_data, out_mul_data, out_last
  );
endinterface

// File: rtl/sdp_nrdma_operand_join.sv
// sdp_nrdma_operand_join: joins N-RDMA ALU/MUL operand streams into one beat-aligned BN operand stream
module sdp_nrdma_operand_join #(parameter int DW = 256) (
  input  logic                     nvdla_core_clk,
  input  logic                     nvdla_core_rstn,
  input  logic                     op_load,
  input  logic [1:0]               reg2dp_data_use,
  sdp_nrdma_operand_join_if.slave  io,
  output logic                     layer_done,
  output logic                     last_mismatch_err,
  output logic [31:0]              beat_count
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t        state;
  logic [1:0]    mode;
  logic          use_alu, use_mul, run, space, pop, join_ok, alu_last, mul_last, join_last;
  logic          out_valid, out_last;
  logic [DW-1:0] alu_data, mul_data;
  assign use_alu   = mode != 2'd0;
  assign use_mul   = mode != 2'd1;
  assign run       = state == RUN;
  assign space     = !out_valid | io.out_ready;
  assign pop       = out_valid & io.out_ready;
  assign alu_last  = io.alu_in_pd[DW];
  assign mul_last  = io.mul_in_pd[DW];
  assign join_ok   = run & (io.alu_in_valid | !use_alu) & (io.mul_in_valid | !use_mul) & space;
  assign join_last = (use_alu & use_mul) ? (alu_last | mul_last) : use_alu ? alu_last : mul_last;
  assign io.alu_in_ready = run & use_alu & (io.mul_in_valid | !use_mul) & space;
  assign io.mul_in_ready = run & use_mul & (io.alu_in_valid | !use_alu) & space;
  assign io.out_valid    = out_valid;
  assign io.out_alu_data = alu_data;
  assign io.out_mul_data = mul_data;
  assign io.out_last     = out_last;
  // layer FSM with the output register, status flags and beat counter
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn)
    if (!nvdla_core_rstn) begin
      state             <= IDLE;
      mode              <= 2'd2;
      out_valid         <= 1'b0;
      out_last          <= 1'b0;
      alu_data          <= '0;
      mul_data          <= '0;
      layer_done        <= 1'b0;
      last_mismatch_err <= 1'b0;
      beat_count        <= '0;
    end else begin
      layer_done <= 1'b0;
      if (join_ok) begin
        out_valid <= 1'b1;
        out_last  <= join_last;
        alu_data  <= use_alu ? io.alu_in_pd[DW-1:0] : '0;
        mul_data  <= use_mul ? io.mul_in_pd[DW-1:0] : '0;
      end else if (pop)
        out_valid <= 1'b0;
      if (pop)
        beat_count <= beat_count + 32'd1;
      if (join_ok & use_alu & use_mul & (alu_last != mul_last))
        last_mismatch_err <= 1'b1;
      case (state)
        IDLE: if (op_load) begin
          state             <= RUN;
          mode              <= reg2dp_data_use;
          beat_count        <= '0;
          last_mismatch_err <= 1'b0;
        end
        RUN: if (join_ok & join_last) state <= DRAIN;
        DRAIN: if (space) begin
          state      <= IDLE;
          layer_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sdp_nrdma_operand_join.sv
// tb_sdp_nrdma_operand_join: directed scoreboard bench for the N-RDMA operand join
module tb_sdp_nrdma_operand_join;
  localparam int DW = 16;
  logic clk = 0, rstn = 1, op_load = 0, sent = 0;
  logic [1:0] data_use = 2'd2, tb_mode = 2'd2;
  logic layer_done, err;
  logic [31:0] beat_count;
  logic [3:0] pat = 4'b1001;
  int tests = 0, fails = 0, cyc = 0, last_pop_cyc = 0, done_cyc = 0, done_cnt = 0, done_base = 0;
  logic [2*DW:0] q[$];
  logic held_v = 0;
  logic [2*DW:0] held;
  sdp_nrdma_operand_join_if #(.DW(DW)) io();
  sdp_nrdma_operand_join #(.DW(DW)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .op_load(op_load), .reg2dp_data_use(data_use),
    .io(io), .layer_done(layer_done), .last_mismatch_err(err), .beat_count(beat_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  // output monitor: pops the scoreboard on every accepted beat, checks stall behaviour
  always @(negedge clk) begin : mon
    logic [2*DW:0] got;
    got = {io.out_alu_data, io.out_mul_data, io.out_last};
    if (held_v && io.out_valid) chk("hold", got, held);
    held_v = rstn && io.out_valid && !io.out_ready;
    held = got;
    if (held_v) chk("stall_ready", {io.alu_in_ready, io.mul_in_ready}, 0);
    if (layer_done) begin done_cnt++; done_cyc = cyc; end
    if (io.out_valid && io.out_ready) begin
      if (q.size() == 0) chk("unexpected_beat", q.size(), 1);
      else chk("beat", got, q.pop_front());
      if (io.out_last) last_pop_cyc = cyc;
    end
  end
  task automatic start(input logic [1:0] md);
    tb_mode = md; data_use = md; op_load = 1; done_base = done_cnt;
    @(posedge clk); #1 op_load = 0;
  endtask
  task automatic beat(input logic [DW-1:0] a, input logic al, input logic [DW-1:0] m, input logic ml, input logic el);
    logic acc = 0;
    q.push_back({(tb_mode != 2'd0) ? a : {DW{1'b0}}, (tb_mode != 2'd1) ? m : {DW{1'b0}}, el});
    io.alu_in_pd = {al, a}; io.mul_in_pd = {ml, m};
    io.alu_in_valid = 1; io.mul_in_valid = 1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = (tb_mode == 2'd0) ? io.mul_in_ready : io.alu_in_ready;
      if (acc && tb_mode == 2'd0) chk("alu_ready_off", io.alu_in_ready, 0);
      @(posedge clk); #1;
    end
    chk("accept", acc, 1);
  endtask
  task automatic wait_done(input int n, input logic e);
    io.alu_in_valid = 0; io.mul_in_valid = 0;
    for (int i = 0; i < 50 && done_cnt == done_base; i++) @(negedge clk);
    chk("layer_done", done_cnt - done_base, 1);
    chk("done_latency", done_cyc - last_pop_cyc, 1);
    chk("beat_count", beat_count, n);
    chk("mismatch_err", err, e);
    @(negedge clk); @(negedge clk);
    chk("done_pulse", done_cnt - done_base, 1);
    chk("count_hold", beat_count, n);
    chk("drained", q.size(), 0);
    @(posedge clk); #1;
  endtask
  initial begin
    io.alu_in_valid = 0; io.mul_in_valid = 0; io.out_ready = 1;
    io.alu_in_pd = '0; io.mul_in_pd = '0;
    #2 rstn = 0;
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    @(negedge clk);
    chk("reset_state", {io.out_valid, io.out_last, io.alu_in_ready, io.mul_in_ready, layer_done, err,
                        io.out_alu_data, io.out_mul_data}, 0);
    chk("reset_count", beat_count, 0);
    @(posedge clk); #1;
    // both streams, back-to-back, last on beat 8
    start(2'd2);
    for (int i = 1; i <= 8; i++) beat(16'(16'hA000 + i), i == 8, 16'(16'hB000 + i), i == 8, i == 8);
    wait_done(8, 0);
    // MUL only; ALU marker ignored, ALU never ready
    start(2'd0);
    for (int i = 1; i <= 4; i++) beat(16'(16'hA100 + i), i == 2, 16'(16'hB100 + i), i == 4, i == 4);
    wait_done(4, 0);
    // MUL arrives three cycles after ALU
    start(2'd2);
    q.push_back({16'hA1F1, 16'hB1F1, 1'b1});
    io.alu_in_pd = {1'b1, 16'hA1F1}; io.alu_in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("alu_wait", io.alu_in_ready, 0);
      @(posedge clk); #1;
    end
    io.mul_in_pd = {1'b1, 16'hB1F1}; io.mul_in_valid = 1;
    @(negedge clk); chk("pair_ready", {io.alu_in_ready, io.mul_in_ready}, 2'b11);
    @(posedge clk); #1 io.alu_in_valid = 0; io.mul_in_valid = 0;
    @(negedge clk); chk("join_latency", io.out_valid, 1);
    @(posedge clk); #1;
    wait_done(1, 0);
    // downstream backpressure pattern 1,0,0,1
    start(2'd2);
    sent = 0;
    fork
      begin
        for (int i = 1; i <= 6; i++) beat(16'(16'hA200 + i), i == 6, 16'(16'hB200 + i), i == 6, i == 6);
        sent = 1;
      end
      begin
        for (int k = 0; k < 100 && !(sent && q.size() == 0); k++) begin
          io.out_ready = pat[k % 4];
          @(posedge clk); #1;
        end
        io.out_ready = 1;
      end
    join
    wait_done(6, 0);
    // ALU last on beat 5, MUL last would be on beat 6
    start(2'd2);
    for (int i = 1; i <= 4; i++) beat(16'(16'hA400 + i), 0, 16'(16'hB400 + i), 0, 0);
    beat(16'hA405, 1, 16'hB405, 0, 1);
    io.mul_in_pd = {1'b1, 16'hB406};
    @(negedge clk);
    chk("drain_ready", {io.alu_in_ready, io.mul_in_ready}, 0);
    chk("err_set", err, 1);
    wait_done(5, 1);
    start(2'd2);
    @(negedge clk); chk("err_clear", err, 0);
    @(posedge clk); #1;
    beat(16'hA4F0, 1, 16'hB4F0, 1, 1);
    wait_done(1, 0);
    // asynchronous reset mid-layer with a stalled output
    start(2'd2);
    beat(16'hA301, 0, 16'hB301, 0, 0);
    beat(16'hA302, 0, 16'hB302, 0, 0);
    io.out_ready = 0; io.alu_in_valid = 0; io.mul_in_valid = 0;
    @(negedge clk);
    chk("pre_reset_valid", io.out_valid, 1);
    chk("pre_reset_count", beat_count, 1);
    #1 rstn = 0;
    #1;
    chk("rst_valid", io.out_valid, 0);
    chk("rst_count", beat_count, 0);
    q.delete();
    @(posedge clk); #1 rstn = 1;
    io.alu_in_pd = {1'b1, 16'hA3FF}; io.mul_in_pd = {1'b1, 16'hB3FF};
    io.alu_in_valid = 1; io.mul_in_valid = 1; io.out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("idle_hold", {io.alu_in_ready, io.mul_in_ready, io.out_valid}, 0);
      @(posedge clk); #1;
    end
    start(2'd2);
    beat(16'hA3FF, 1, 16'hB3FF, 1, 1);
    wait_done(1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sdp_nrdma_operand_join.md
Name: sdp_nrdma_operand_join

Overview:
- Sits directly downstream of the SDP N-RDMA egress. Consumes its two operand streams (ALU, MUL) and joins them into one beat-aligned operand stream for the BN datapath.
- Gates acceptance per layer according to the configured data-use mode and tracks the end-of-layer marker.
- Reports layer completion, a sticky last-marker mismatch error, and a per-layer beat count.

Parameters:
- DW, 256, operand data bits per beat. The input pd width is DW+1, with pd[DW] = layer-end marker and pd[DW-1:0] = data.

Ports:
- nvdla_core_clk  in  1  clock
- nvdla_core_rstn  in  1  reset, asynchronous, active-low
- op_load  in  1  single-cycle layer start pulse
- reg2dp_data_use  in  2  0=MUL only, 1=ALU only, 2 or 3=both; sampled on op_load
- alu_in_valid  in  1  ALU operand valid
- alu_in_ready  out  1  ALU operand ready
- alu_in_pd  in  DW+1  ALU operand {last, data}
- mul_in_valid  in  1  MUL operand valid
- mul_in_ready  out  1  MUL operand ready
- mul_in_pd  in  DW+1  MUL operand {last, data}
- out_valid  out  1  joined beat valid
- out_ready  in  1  downstream ready
- out_alu_data  out  DW  ALU data; 0 when ALU is unused
- out_mul_data  out  DW  MUL data; 0 when MUL is unused
- out_last  out  1  layer-end beat
- layer_done  out  1  single-cycle pulse when the layer has fully drained
- last_mismatch_err  out  1  sticky error, cleared on op_load
- beat_count  out  32  joined beats emitted in the current layer

Behaviour:
- Reset values: all ready/valid outputs 0; data outputs 0; out_last 0; layer_done 0; last_mismatch_err 0; beat_count 0; FSM in IDLE; latched use mode = both.
- FSM has three states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on op_load. In the same cycle: latch reg2dp_data_use, clear beat_count and last_mismatch_err.
  - RUN -> DRAIN on the cycle a join completes with joined last = 1.
  - DRAIN -> IDLE when the output register is empty, or is emptying this cycle (out_valid & out_ready). layer_done pulses for exactly one cycle on this transition.
  - op_load in RUN or DRAIN is ignored, with no effect on any state.
- Enables: use_alu = (mode != 0); use_mul = (mode != 1).
- Join condition, evaluated in RUN only:
  - join = (alu_in_valid | !use_alu) & (mul_in_valid | !use_mul) & space
  - space = !out_valid | out_ready
- Ready generation:
  - alu_in_ready = RUN & use_alu & (mul_in_valid | !use_mul) & space
  - mul_in_ready is symmetric.
  - Ready never asserts for a disabled stream, in IDLE, or in DRAIN. No input beat is consumed unless its partner is consumed in the same cycle.
- Output register: single stage, full throughput, 1-cycle latency from join to out_valid.
  - Loads on join; data and last hold while out_valid & !out_ready.
  - The data field of an unused stream loads 0.
  - out_valid clears when out_ready is high and no new join occurs.
- Joined last:
  - Both streams enabled: last = alu_last | mul_last. If alu_last != mul_last at join, last_mismatch_err sets and stays set until the next op_load.
  - Single stream enabled: last is that stream's marker.
- beat_count:
  - Increments on each out_valid & out_ready; wraps at 2^32.
  - Holds its value after layer_done until the next op_load.
- Simultaneous events:
  - Output pop and join in the same cycle: the register reloads and out_valid stays high.
  - Join with last while the output stalls: FSM goes to DRAIN and layer_done waits for the pop.
- Asynchronous reset mid-layer returns everything to reset values immediately. In-flight beats are dropped.
- Inputs arriving in IDLE or DRAIN are held off by ready = 0 and are not lost.

Test Plan:
- Mode 2, both streams valid every cycle, out_ready = 1, 8 beats with last on beat 8 -> 8 output beats, each 1 cycle after its join. layer_done pulses 1 cycle after beat 8 pops. beat_count = 8. last_mismatch_err = 0.
- Mode 0 (MUL only), alu_in_valid = 1 throughout -> alu_in_ready stays 0. out_alu_data = 0 on every beat. out_mul_data matches the input in order. 4 beats give beat_count = 4.
- Mode 2, MUL arrives 3 cycles after ALU -> alu_in_ready stays low until mul_in_valid rises. Both readies then pulse together in one cycle, and one beat is emitted.
- out_ready toggling 1,0,0,1 with continuous inputs -> no beat lost or duplicated. Output data is stable while stalled. Input readies drop in the cycles where out_valid & !out_ready.
- Mode 2, ALU last on beat 5, MUL last on beat 6 -> out_last on beat 5, last_mismatch_err = 1, FSM enters DRAIN with readies at 0. A following op_load clears the error.
- Reset asserted mid-layer with out_valid = 1 -> out_valid = 0, beat_count = 0, FSM in IDLE. A later op_load starts cleanly and inputs stay not-ready until it arrives.
